// File: rtl/forward_sel_unit.sv
// rtl/forward_sel_unit.sv - EX-stage operand forwarding select and load-use stall
//
// Tracks destination register and write/load flags of the instructions in EX,
// MEM and WB, compares them with the sources of the instruction leaving ID and
// registers the ALU operand mux selects for the coming EX cycle.
//
// Ports:
//   Clk        in   1  rising-edge clock
//   Rst        in   1  asynchronous active-low reset
//   IdValid    in   1  ID holds a real instruction
//   IdRs       in   5  ID source register A
//   IdRt       in   5  ID source register B
//   IdDst      in   5  ID destination register
//   IdRegWrite in   1  ID instruction writes the register file
//   IdMemRead  in   1  ID instruction is a load
//   Flush      in   1  discard the ID instruction
//   SelA       out  2  operand-A select for the instruction in EX
//   SelB       out  2  operand-B select for the instruction in EX
//   Stall      out  1  load-use hazard, hold PC and IF/ID

module forward_sel_unit (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       IdValid,
  input  logic [4:0] IdRs,
  input  logic [4:0] IdRt,
  input  logic [4:0] IdDst,
  input  logic       IdRegWrite,
  input  logic       IdMemRead,
  input  logic       Flush,
  output logic [1:0] SelA,
  output logic [1:0] SelB,
  output logic       Stall
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [1:0] SEL_RET = 2'b11;

  logic [4:0] ex_dst;
  logic       ex_rw;
  logic       ex_mr;
  logic [4:0] mem_dst;
  logic       mem_rw;
  logic [4:0] wb_dst;
  logic       wb_rw;

  logic       bubble;
  logic [1:0] next_a;
  logic [1:0] next_b;

  // Nearest producer wins; $0 is hardwired and never forwards. The EX
  // producer is one stage further along by the time the consumer is in EX,
  // hence each stage maps to the mux input one step downstream.
  function automatic logic [1:0] pick(
    input logic [4:0] s,
    input logic [4:0] e_dst, input logic e_rw,
    input logic [4:0] m_dst, input logic m_rw,
    input logic [4:0] w_dst, input logic w_rw
  );
    logic [1:0] r;
    r = SEL_RF;
    if (s == 5'd0)                  r = SEL_RF;
    else if (e_rw && e_dst == s)    r = SEL_MEM;
    else if (m_rw && m_dst == s)    r = SEL_WB;
    else if (w_rw && w_dst == s)    r = SEL_RET;
    return r;
  endfunction

  always_comb begin
    Stall = IdValid && ex_rw && ex_mr && (ex_dst != 5'd0) &&
            ((ex_dst == IdRs) || (ex_dst == IdRt));
  end

  assign bubble = Stall || Flush || !IdValid;

  always_comb begin
    next_a = pick(IdRs, ex_dst, ex_rw, mem_dst, mem_rw, wb_dst, wb_rw);
    next_b = pick(IdRt, ex_dst, ex_rw, mem_dst, mem_rw, wb_dst, wb_rw);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ex_dst  <= 5'd0;
      ex_rw   <= 1'b0;
      ex_mr   <= 1'b0;
      mem_dst <= 5'd0;
      mem_rw  <= 1'b0;
      wb_dst  <= 5'd0;
      wb_rw   <= 1'b0;
      SelA    <= SEL_RF;
      SelB    <= SEL_RF;
    end else begin
      mem_dst <= ex_dst;
      mem_rw  <= ex_rw;
      wb_dst  <= mem_dst;
      wb_rw   <= mem_rw;
      if (bubble) begin
        // A bubble never writes, so it can never become a forwarding source.
        ex_dst <= 5'd0;
        ex_rw  <= 1'b0;
        ex_mr  <= 1'b0;
        SelA   <= SEL_RF;
        SelB   <= SEL_RF;
      end else begin
        ex_dst <= IdDst;
        ex_rw  <= IdRegWrite;
        ex_mr  <= IdMemRead;
        SelA   <= next_a;
        SelB   <= next_b;
      end
    end
  end

endmodule

// File: tb/tb_forward_sel_unit.sv
// tb/tb_forward_sel_unit.sv - directed table-driven bench for forward_sel_unit

module tb_forward_sel_unit;

  logic       Clk;
  logic       Rst;
  logic       IdValid;
  logic [4:0] IdRs;
  logic [4:0] IdRt;
  logic [4:0] IdDst;
  logic       IdRegWrite;
  logic       IdMemRead;
  logic       Flush;
  logic [1:0] SelA;
  logic [1:0] SelB;
  logic       Stall;

  int checks;
  int errors;

  forward_sel_unit dut (
    .Clk(Clk), .Rst(Rst), .IdValid(IdValid), .IdRs(IdRs), .IdRt(IdRt),
    .IdDst(IdDst), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
    .Flush(Flush), .SelA(SelA), .SelB(SelB), .Stall(Stall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       rw;
    logic       mr;
    logic       fl;
    logic       st;
    logic [1:0] a;
    logic [1:0] b;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] dst, input logic rw, input logic mr,
                     input logic fl, input logic st, input logic [1:0] a,
                     input logic [1:0] b);
    vec_t x;
    x = '{v:v, rs:rs, rt:rt, dst:dst, rw:rw, mr:mr, fl:fl, st:st, a:a, b:b};
    vecs.push_back(x);
  endtask

  task automatic add_bub3();
    for (int i = 0; i < 3; i++) add(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic chk(input string nm, input int idx, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %b expected %b", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    IdValid    = x.v;
    IdRs       = x.rs;
    IdRt       = x.rt;
    IdDst      = x.dst;
    IdRegWrite = x.rw;
    IdMemRead  = x.mr;
    Flush      = x.fl;
  endtask

  task automatic step(input vec_t x, input int idx);
    @(negedge Clk);
    drive(x);
    #1;
    chk("stall", idx, {1'b0, Stall}, {1'b0, x.st});
    @(posedge Clk);
    #1;
    chk("sel_a", idx, SelA, x.a);
    chk("sel_b", idx, SelB, x.b);
  endtask

  initial begin
    vec_t t;
    checks = 0;
    errors = 0;

    // Garbage on every input, reset asserted asynchronously before any edge.
    Rst = 1'b1;
    IdValid = 1'b1; IdRs = 5'd7; IdRt = 5'd7; IdDst = 5'd7;
    IdRegWrite = 1'b1; IdMemRead = 1'b1; Flush = 1'b0;
    #2 Rst = 1'b0;
    #1;
    chk("rst_sel_a", -1, SelA, 2'b00);
    chk("rst_sel_b", -1, SelB, 2'b00);
    chk("rst_stall", -1, {1'b0, Stall}, 2'b00);
    @(negedge Clk);
    Rst = 1'b1;

    //   v  rs     rt     dst    rw mr fl  st  a      b
    // back-to-back ALU dependency
    add(1, 5'd1,  5'd2,  5'd3,  1, 0, 0,  0, 2'b00, 2'b00);
    add(1, 5'd3,  5'd4,  5'd9,  1, 0, 0,  0, 2'b01, 2'b00);
    add_bub3();
    // distance 2
    add(1, 5'd1,  5'd2,  5'd5,  1, 0, 0,  0, 2'b00, 2'b00);
    add(1, 5'd11, 5'd12, 5'd10, 1, 0, 0,  0, 2'b00, 2'b00);
    add(1, 5'd13, 5'd5,  5'd14, 1, 0, 0,  0, 2'b00, 2'b10);
    add_bub3();
    // distance 3
    add(1, 5'd1,  5'd2,  5'd5,  1, 0, 0,  0, 2'b00, 2'b00);
    add(1, 5'd11, 5'd12, 5'd10, 1, 0, 0,  0, 2'b00, 2'b00);
    add(1, 5'd11, 5'd12, 5'd15, 1, 0, 0,  0, 2'b00, 2'b00);
    add(1, 5'd13, 5'd5,  5'd14, 1, 0, 0,  0, 2'b00, 2'b11);
    add_bub3();
    // load-use on rs: one stall cycle, then select 10
    add(1, 5'd1,  5'd2,  5'd8,  1, 1, 0,  0, 2'b00, 2'b00);
    add(1, 5'd8,  5'd2,  5'd16, 1, 0, 0,  1, 2'b00, 2'b00);
    add(1, 5'd8,  5'd2,  5'd16, 1, 0, 0,  0, 2'b10, 2'b00);
    add_bub3();
    // load into $0 neither stalls nor forwards
    add(1, 5'd1,  5'd2,  5'd0,  1, 1, 0,  0, 2'b00, 2'b00);
    add(1, 5'd0,  5'd0,  5'd17, 1, 0, 0,  0, 2'b00, 2'b00);
    add_bub3();
    // two producers of $4, nearest wins; same source on both sides
    add(1, 5'd1,  5'd2,  5'd4,  1, 0, 0,  0, 2'b00, 2'b00);
    add(1, 5'd1,  5'd2,  5'd4,  1, 0, 0,  0, 2'b00, 2'b00);
    add(1, 5'd4,  5'd4,  5'd18, 1, 0, 0,  0, 2'b01, 2'b01);
    add_bub3();
    // flushed producer never forwards
    add(1, 5'd1,  5'd2,  5'd6,  1, 0, 1,  0, 2'b00, 2'b00);
    add(1, 5'd6,  5'd6,  5'd19, 1, 0, 0,  0, 2'b00, 2'b00);
    add_bub3();
    // flush together with stall is just a bubble
    add(1, 5'd1,  5'd2,  5'd7,  1, 1, 0,  0, 2'b00, 2'b00);
    add(1, 5'd7,  5'd2,  5'd20, 1, 0, 1,  1, 2'b00, 2'b00);
    add(1, 5'd7,  5'd2,  5'd20, 1, 0, 0,  0, 2'b10, 2'b00);
    add_bub3();
    // load-use on rt
    add(1, 5'd1,  5'd2,  5'd20, 1, 1, 0,  0, 2'b00, 2'b00);
    add(1, 5'd1,  5'd20, 5'd21, 1, 0, 0,  1, 2'b00, 2'b00);
    add(1, 5'd1,  5'd20, 5'd21, 1, 0, 0,  0, 2'b00, 2'b10);
    add_bub3();
    // invalid ID slot does not stall on a load match
    add(1, 5'd1,  5'd2,  5'd21, 1, 1, 0,  0, 2'b00, 2'b00);
    add(0, 5'd21, 5'd2,  5'd22, 1, 0, 0,  0, 2'b00, 2'b00);
    add(1, 5'd21, 5'd2,  5'd22, 1, 0, 0,  0, 2'b10, 2'b00);
    add_bub3();

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Reset mid-stream drops a pending load-use hazard.
    t = '{v:1, rs:5'd1, rt:5'd2, dst:5'd23, rw:1, mr:1, fl:0, st:0, a:2'b00, b:2'b00};
    step(t, 1000);
    t = '{v:1, rs:5'd23, rt:5'd23, dst:5'd24, rw:1, mr:0, fl:0, st:0, a:2'b00, b:2'b00};
    @(negedge Clk);
    drive(t);
    #1;
    chk("pre_rst_stall", 1001, {1'b0, Stall}, 2'b01);
    #1 Rst = 1'b0;
    #1;
    chk("mid_rst_stall", 1001, {1'b0, Stall}, 2'b00);
    chk("mid_rst_sel_a", 1001, SelA, 2'b00);
    chk("mid_rst_sel_b", 1001, SelB, 2'b00);
    @(negedge Clk);
    Rst = 1'b1;
    step(t, 1002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
